// File: rtl/router_terminal_if.sv
// router_terminal_if: per-terminal FIFO handshake between router_bus_gnrtr (master) and a terminal (slave)
interface router_terminal_if #(parameter int pckg_sz = 32);
  logic [pckg_sz-1:0] data_out_i_in;
  logic [pckg_sz-1:0] data_out;
  logic pndng_i_in;
  logic popin;
  logic pndng;
  logic pop;
  modport master (input data_out_i_in, pndng_i_in, pop, output popin, data_out, pndng);
  modport slave (output data_out_i_in, pndng_i_in, pop, input popin, data_out, pndng);
endinterface

// File: rtl/router_terminal.sv
// router_terminal: bus endpoint with a TX FIFO toward the bus and a destination-filtered RX holding register
module router_terminal #(
  parameter int pckg_sz = 32,
  parameter int fifo_depth = 16,
  parameter logic [7:0] term_id = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_push,
  input  logic [7:0]                    tx_dest,
  input  logic [pckg_sz-9:0]            tx_payload,
  output logic                          tx_full,
  output logic [$clog2(fifo_depth):0]   tx_count,
  output logic [15:0]                   tx_drop_cnt,
  output logic                          rx_valid,
  output logic [pckg_sz-1:0]            rx_data,
  input  logic                          rx_ready,
  output logic [15:0]                   misroute_cnt,
  router_terminal_if.slave              bus
);
  localparam int aw = $clog2(fifo_depth);
  localparam int cw = aw + 1;
  typedef enum logic {RX_IDLE, RX_HOLD} state_t;
  logic [pckg_sz-1:0] mem [fifo_depth];
  logic [aw-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic [15:0] drop_q, drop_d, mis_q, mis_d;
  state_t state_q, state_d;
  logic rx_valid_q, rx_valid_d;
  logic [pckg_sz-1:0] rx_data_q, rx_data_d;
  logic tx_pop, tx_ok, accept, rx_take;
  assign tx_full = cnt_q == cw'(fifo_depth);
  assign tx_count = cnt_q;
  assign tx_drop_cnt = drop_q;
  assign misroute_cnt = mis_q;
  assign rx_valid = rx_valid_q;
  assign rx_data = rx_data_q;
  assign bus.pndng_i_in = cnt_q != '0 && !reset;
  assign bus.data_out_i_in = cnt_q != '0 ? mem[rd_q] : '0;
  // gated by reset so the bus sees pop drop as soon as reset rises
  assign bus.pop = bus.pndng && state_q == RX_IDLE && !reset;
  always_comb begin
    tx_pop = bus.popin && cnt_q != '0;
    tx_ok = tx_push && (!tx_full || tx_pop);
    wr_d = tx_ok ? wr_q + aw'(1) : wr_q;
    rd_d = tx_pop ? rd_q + aw'(1) : rd_q;
    cnt_d = (tx_ok && !tx_pop) ? cnt_q + cw'(1) : (!tx_ok && tx_pop) ? cnt_q - cw'(1) : cnt_q;
    drop_d = (tx_push && !tx_ok && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    accept = bus.data_out[pckg_sz-1 -: 8] == term_id || bus.data_out[pckg_sz-1 -: 8] == broadcast;
    rx_take = bus.pop && accept;
    mis_d = (bus.pop && !accept && mis_q != 16'hFFFF) ? mis_q + 16'd1 : mis_q;
    state_d = state_q == RX_IDLE ? (rx_take ? RX_HOLD : RX_IDLE) : (rx_ready ? RX_IDLE : RX_HOLD);
    rx_valid_d = state_d == RX_HOLD;
    rx_data_d = rx_take ? bus.data_out : rx_data_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      drop_q <= '0;
      mis_q <= '0;
      state_q <= RX_IDLE;
      rx_valid_q <= 1'b0;
      rx_data_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      drop_q <= drop_d;
      mis_q <= mis_d;
      state_q <= state_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q <= rx_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (tx_ok) mem[wr_q] <= {tx_dest, tx_payload};
  end
endmodule

// File: tb/tb_router_terminal.sv
// tb_router_terminal: directed checks of TX FIFO, RX filtering/hold and mid-operation reset
module tb_router_terminal;
  logic clk = 1'b0;
  logic reset;
  logic tx_push;
  logic [7:0] tx_dest;
  logic [23:0] tx_payload;
  logic tx_full;
  logic [4:0] tx_count;
  logic [15:0] tx_drop_cnt;
  logic rx_valid;
  logic [31:0] rx_data;
  logic rx_ready;
  logic [15:0] misroute_cnt;
  int errors = 0;
  int checks = 0;
  router_terminal_if #(.pckg_sz(32)) bus ();
  router_terminal #(.pckg_sz(32), .fifo_depth(16), .term_id(8'd3), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .tx_push(tx_push), .tx_dest(tx_dest), .tx_payload(tx_payload),
    .tx_full(tx_full), .tx_count(tx_count), .tx_drop_cnt(tx_drop_cnt), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .misroute_cnt(misroute_cnt), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    tx_push = 1'b0;
    tx_dest = '0;
    tx_payload = '0;
    rx_ready = 1'b0;
    bus.popin = 1'b0;
    bus.pndng = 1'b0;
    bus.data_out = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_pndng_i_in", 32'(bus.pndng_i_in), 32'd0);
    chk("rst_pop", 32'(bus.pop), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_tx_count", 32'(tx_count), 32'd0);
    chk("rst_drop", 32'(tx_drop_cnt), 32'd0);
    chk("rst_misroute", 32'(misroute_cnt), 32'd0);
    chk("rst_data_out_i_in", bus.data_out_i_in, 32'd0);
    chk("rst_tx_full", 32'(tx_full), 32'd0);
    tx_push = 1'b1;
    tx_dest = 8'h05;
    tx_payload = 24'hABCDEF;
    tick();
    tx_push = 1'b0;
    #1;
    chk("tx1_head", bus.data_out_i_in, 32'h05ABCDEF);
    chk("tx1_pndng", 32'(bus.pndng_i_in), 32'd1);
    chk("tx1_count", 32'(tx_count), 32'd1);
    bus.popin = 1'b1;
    tick();
    bus.popin = 1'b0;
    #1;
    chk("tx1_pop_pndng", 32'(bus.pndng_i_in), 32'd0);
    chk("tx1_pop_count", 32'(tx_count), 32'd0);
    chk("tx1_empty_head", bus.data_out_i_in, 32'd0);
    bus.popin = 1'b1;
    tick();
    bus.popin = 1'b0;
    #1;
    chk("popin_empty_count", 32'(tx_count), 32'd0);
    chk("popin_empty_drop", 32'(tx_drop_cnt), 32'd0);
    for (int i = 0; i < 17; i++) begin
      tx_push = 1'b1;
      tx_dest = 8'(i);
      tx_payload = 24'h000100 + 24'(i);
      tick();
    end
    tx_push = 1'b0;
    #1;
    chk("fill_full", 32'(tx_full), 32'd1);
    chk("fill_count", 32'(tx_count), 32'd16);
    chk("fill_drop", 32'(tx_drop_cnt), 32'd1);
    chk("fill_head", bus.data_out_i_in, 32'h00000100);
    tx_push = 1'b1;
    tx_dest = 8'h20;
    tx_payload = 24'h000120;
    bus.popin = 1'b1;
    tick();
    tx_push = 1'b0;
    bus.popin = 1'b0;
    #1;
    chk("full_pushpop_count", 32'(tx_count), 32'd16);
    chk("full_pushpop_drop", 32'(tx_drop_cnt), 32'd1);
    chk("full_pushpop_head", bus.data_out_i_in, 32'h01000101);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("drain_%0d", k), bus.data_out_i_in,
          k < 15 ? {8'(k + 1), 24'h000101 + 24'(k)} : 32'h20000120);
      bus.popin = 1'b1;
      tick();
    end
    bus.popin = 1'b0;
    #1;
    chk("drain_count", 32'(tx_count), 32'd0);
    chk("drain_pndng", 32'(bus.pndng_i_in), 32'd0);
    bus.data_out = 32'h03000001;
    bus.pndng = 1'b1;
    #1;
    chk("rx1_pop", 32'(bus.pop), 32'd1);
    tick();
    bus.data_out = 32'h03000002;
    #1;
    chk("rx1_valid", 32'(rx_valid), 32'd1);
    chk("rx1_data", rx_data, 32'h03000001);
    chk("rx1_hold_pop", 32'(bus.pop), 32'd0);
    tick();
    chk("rx1_hold_pop2", 32'(bus.pop), 32'd0);
    chk("rx1_hold_data", rx_data, 32'h03000001);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    #1;
    chk("rx1_released", 32'(rx_valid), 32'd0);
    chk("rx2_pop", 32'(bus.pop), 32'd1);
    tick();
    chk("rx2_valid", 32'(rx_valid), 32'd1);
    chk("rx2_data", rx_data, 32'h03000002);
    rx_ready = 1'b1;
    bus.pndng = 1'b0;
    tick();
    rx_ready = 1'b0;
    chk("rx2_released", 32'(rx_valid), 32'd0);
    bus.data_out = 32'h07000000;
    bus.pndng = 1'b1;
    #1;
    chk("mis_pop", 32'(bus.pop), 32'd1);
    tick();
    bus.data_out = 32'hFF000002;
    #1;
    chk("mis_cnt", 32'(misroute_cnt), 32'd1);
    chk("mis_no_valid", 32'(rx_valid), 32'd0);
    chk("bc_pop", 32'(bus.pop), 32'd1);
    tick();
    bus.pndng = 1'b0;
    #1;
    chk("bc_valid", 32'(rx_valid), 32'd1);
    chk("bc_data", rx_data, 32'hFF000002);
    chk("bc_mis_cnt", 32'(misroute_cnt), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tx_push = 1'b1;
      tx_dest = 8'h40;
      tx_payload = 24'(i);
      tick();
    end
    tx_push = 1'b0;
    bus.data_out = 32'h03000009;
    bus.pndng = 1'b1;
    #1;
    chk("pre_rst_count", 32'(tx_count), 32'd5);
    chk("pre_rst_valid", 32'(rx_valid), 32'd1);
    chk("pre_rst_hold_pop", 32'(bus.pop), 32'd0);
    reset = 1'b1;
    #1;
    chk("async_rst_pndng_i_in", 32'(bus.pndng_i_in), 32'd0);
    chk("async_rst_pop", 32'(bus.pop), 32'd0);
    chk("async_rst_valid", 32'(rx_valid), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_count", 32'(tx_count), 32'd0);
    chk("post_rst_head", bus.data_out_i_in, 32'd0);
    chk("post_rst_mis", 32'(misroute_cnt), 32'd0);
    chk("post_rst_idle_pop", 32'(bus.pop), 32'd1);
    tick();
    chk("post_rst_valid", 32'(rx_valid), 32'd1);
    chk("post_rst_data", rx_data, 32'h03000009);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/router_terminal.md
Name: router_terminal

Overview:
- Synthesizable endpoint for one terminal of `router_bus_gnrtr`; it is the device on the far side of the bus's per-terminal FIFO handshake.
- TX side: buffers locally generated packets in a FIFO. It presents the head on `data_out_i_in`/`pndng_i_in` and retires it when the bus asserts `popin`.
- RX side: drains the bus's output FIFO via `pndng`/`data_out`/`pop`, filters on destination ID, and hands accepted packets to local logic through a valid/ready register.
- One instance per terminal replaces the behavioural driver/monitor pair in system-level sims.

Parameters:
- `pckg_sz`, 32: packet width in bits; bits [pckg_sz-1:pckg_sz-8] are the destination ID.
- `fifo_depth`, 16: TX FIFO entries; must be a power of 2, at least 2.
- `term_id`, 0: 8-bit ID of this terminal.
- `broadcast`, 8'hFF: destination ID accepted by every terminal.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_push`  in  1  local write strobe.
- `tx_dest`  in  8  destination ID for the pushed packet.
- `tx_payload`  in  pckg_sz-8  payload for the pushed packet.
- `tx_full`  out  1  TX FIFO holds fifo_depth entries.
- `tx_count`  out  $clog2(fifo_depth)+1  TX FIFO occupancy.
- `tx_drop_cnt`  out  16  pushes rejected while full; saturating.
- `data_out_i_in`  out  pckg_sz  TX FIFO head, to bus.
- `pndng_i_in`  out  1  TX FIFO non-empty, to bus.
- `popin`  in  1  bus consumes the TX head.
- `data_out`  in  pckg_sz  bus output FIFO head.
- `pndng`  in  1  bus output FIFO non-empty.
- `pop`  out  1  terminal consumes the bus head.
- `rx_valid`  out  1  accepted packet available.
- `rx_data`  out  pckg_sz  accepted packet.
- `rx_ready`  in  1  local consumer takes `rx_data`.
- `misroute_cnt`  out  16  packets popped with a foreign destination; saturating.

Behaviour:

Reset (asynchronous, immediate):
- TX pointers, `tx_count` and both counters go to 0.
- FSM goes to RX_IDLE.
- `rx_valid`=0, `rx_data`=0, `pop`=0, `pndng_i_in`=0.
- FIFO memory contents are don't-care.

TX FIFO:
- Packet is formed as {tx_dest, tx_payload}.
- Circular buffer with wrapping read/write pointers and a separate count; `tx_full` = (count == fifo_depth).
- `pndng_i_in` = (count != 0), combinational from registered count.
- `data_out_i_in` = mem[rd_ptr] when non-empty, all-zero when empty.
- Pop occurs when `popin` && `pndng_i_in`; `popin` while empty is ignored.
- Push occurs when `tx_push` && (!`tx_full` || pop-this-cycle). Push and pop in the same cycle, including when full, are both accepted and count is unchanged.
- Push rejected while full (with no simultaneous pop) increments `tx_drop_cnt`, saturating at 16'hFFFF.
- Latency: a packet pushed at edge N is visible on `data_out_i_in` after edge N if the FIFO was empty (one cycle).

RX FSM, states RX_IDLE and RX_HOLD:
- `pop` = `pndng` && (state == RX_IDLE), combinational.
- RX_IDLE with `pndng`=1: `data_out` is captured at the edge.
  - dest == term_id or dest == broadcast: `rx_data` <= data_out, `rx_valid` <= 1, go to RX_HOLD.
  - otherwise: discard, `misroute_cnt`++ (saturating), stay in RX_IDLE. Back-to-back misroutes drain one per cycle.
- RX_HOLD:
  - `rx_valid`=1; `rx_data` is stable and `pop`=0 while waiting.
  - `rx_ready`=1: `rx_valid` <= 0, go to RX_IDLE.
  - The next pop cannot occur before the following cycle, so accepted-packet throughput is one per 2 cycles.
- `rx_ready` in RX_IDLE has no effect.

Independence and reset mid-operation:
- TX and RX sides are fully independent; simultaneous activity on both is legal.
- Reset asserted mid-transfer drops all buffered and held packets. `pop` and `pndng_i_in` fall in the same cycle reset rises, before the next clock edge.

Test Plan:
- Reset then idle: `pndng_i_in`=0, `pop`=0, `rx_valid`=0, `tx_count`=0, counters 0, `data_out_i_in`=0.
- term_id=3: push dest=8'h05, payload 24'hABCDEF → `data_out_i_in`=32'h05ABCDEF with `pndng_i_in`=1 the next cycle. One `popin` cycle → `pndng_i_in`=0 and `tx_count`=0.
- fifo_depth=16: push 17 packets with `popin`=0 → `tx_full`=1, `tx_drop_cnt`=1. Then push with `popin`=1 on the same cycle → accepted, `tx_count` stays 16. Drain 16 pops → packets come out in FIFO order; wrap-around preserves order.
- term_id=3, bus presents 32'h03000001 with `rx_ready`=0 → `pop` pulses for one cycle, `rx_valid`=1, `rx_data`=32'h03000001. `pop` stays 0 while held. After `rx_ready`=1 → `rx_valid`=0 and the next packet is popped one cycle later.
- term_id=3, bus presents 32'h07000000, then 32'hFF000002 → first packet: `misroute_cnt`=1 and no `rx_valid`. Broadcast packet is accepted, `rx_data`=32'hFF000002.
- Reset asserted with 5 TX entries queued and RX in RX_HOLD → `pndng_i_in`, `pop` and `rx_valid` deassert before the next edge. After release, `tx_count`=0 and the RX FSM is in RX_IDLE.
